// File: rtl/hack_pkg.sv
// Shared definitions for the Hack controller: sequencer states, instruction
// field positions and the ALU comp codes the ALU understands.
package hack_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MREAD,
        S_EXEC,
        S_WB,
        S_MWRITE
    } state_e;

    localparam int unsigned IR_CI   = 15;
    localparam int unsigned IR_A    = 12;
    localparam int unsigned COMP_HI = 11;
    localparam int unsigned COMP_LO = 6;
    localparam int unsigned DEST_A  = 5;
    localparam int unsigned DEST_D  = 4;
    localparam int unsigned DEST_M  = 3;
    localparam int unsigned JUMP_LT = 2;
    localparam int unsigned JUMP_EQ = 1;
    localparam int unsigned JUMP_GT = 0;

    localparam logic [5:0] COMP_ZERO   = 6'b101010;
    localparam logic [5:0] COMP_ONE    = 6'b111111;
    localparam logic [5:0] COMP_NEG1   = 6'b111010;
    localparam logic [5:0] COMP_X      = 6'b001100;
    localparam logic [5:0] COMP_Y      = 6'b110000;
    localparam logic [5:0] COMP_NOT_X  = 6'b001101;
    localparam logic [5:0] COMP_NOT_Y  = 6'b110001;
    localparam logic [5:0] COMP_NEG_X  = 6'b001111;
    localparam logic [5:0] COMP_NEG_Y  = 6'b110011;
    localparam logic [5:0] COMP_X_INC  = 6'b011111;
    localparam logic [5:0] COMP_Y_INC  = 6'b110111;
    localparam logic [5:0] COMP_X_DEC  = 6'b001110;
    localparam logic [5:0] COMP_Y_DEC  = 6'b110010;
    localparam logic [5:0] COMP_X_ADD  = 6'b000010;
    localparam logic [5:0] COMP_X_SUB  = 6'b010011;
    localparam logic [5:0] COMP_Y_SUB  = 6'b000111;
    localparam logic [5:0] COMP_X_AND  = 6'b000000;
    localparam logic [5:0] COMP_X_OR   = 6'b010101;

    function automatic logic [6:0] alu_opcode(input logic [5:0] comp);
        return {1'b0, comp};
    endfunction

endpackage

// File: rtl/hack_jump_eval.sv
// Combinational jump decision from an ALU result and the three jump bits.
module hack_jump_eval
    import hack_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] result_i,
    input  logic [2:0]        jump_i,
    output logic              take_o
);

    logic zr;
    logic ng;

    always_comb begin
        zr     = (result_i == '0);
        ng     = result_i[DATA_W-1];
        take_o = (jump_i[JUMP_LT] & ng)
               | (jump_i[JUMP_EQ] & zr)
               | (jump_i[JUMP_GT] & ~ng & ~zr);
    end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack instruction sequencer: owns A/D/PC, drives the registered
// ALU and runs the instruction and data memory handshakes.
module hack_cpu_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_data,
    output logic              dmem_re,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [6:0]        alu_op,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] d_out
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              imem_req_c;
    logic              dmem_re_c;
    logic              dmem_we_c;
    logic              take;
    logic [ADDR_W-1:0] pc_inc;

    hack_jump_eval #(
        .DATA_W (DATA_W)
    ) u_jump (
        .result_i (alu_result),
        .jump_i   (ir_q[JUMP_LT:JUMP_GT]),
        .take_o   (take)
    );

    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RST_PC;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            m_q     <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            m_q     <= m_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        d_d        = d_q;
        ir_d       = ir_q;
        m_d        = m_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        imem_req_c = 1'b0;
        dmem_re_c  = 1'b0;
        dmem_we_c  = 1'b0;
        alu_op     = '0;

        unique case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!ir_q[IR_CI]) begin
                    a_d     = DATA_W'(ir_q[DATA_W-2:0]);
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else if (ir_q[IR_A]) begin
                    state_d = S_MREAD;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_MREAD: begin
                dmem_re_c = 1'b1;
                if (dmem_ack) begin
                    m_d     = dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_op  = alu_opcode(ir_q[COMP_HI:COMP_LO]);
                state_d = S_WB;
            end
            S_WB: begin
                // Jump target and write address come from a_q, the A value
                // before this instruction's own A update takes effect.
                if (ir_q[DEST_A]) a_d = alu_result;
                if (ir_q[DEST_D]) d_d = alu_result;
                pc_d = take ? a_q[ADDR_W-1:0] : pc_inc;
                if (ir_q[DEST_M]) begin
                    waddr_d = a_q[ADDR_W-1:0];
                    wdata_d = alu_result;
                    state_d = S_MWRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MWRITE: begin
                dmem_we_c = 1'b1;
                if (dmem_ack) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Requests are masked while reset is held so nothing is issued before
    // the first cycle out of reset.
    assign imem_req   = imem_req_c & ~rst;
    assign dmem_re    = dmem_re_c & ~rst;
    assign dmem_we    = dmem_we_c & ~rst;
    assign imem_addr  = pc_q;
    assign dmem_addr  = (state_q == S_MWRITE) ? waddr_q : a_q[ADDR_W-1:0];
    assign dmem_wdata = wdata_q;
    assign alu_x      = d_q;
    assign alu_y      = ir_q[IR_A] ? m_q : a_q;
    assign pc_out     = pc_q;
    assign a_out      = a_q;
    assign d_out      = d_q;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Randomised bench for hack_cpu_ctrl against an instruction-level Hack model
// with emulated instruction/data memories and a one-cycle registered ALU.
module tb_hack_cpu_ctrl;
    import hack_pkg::*;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_data;
    logic              dmem_re;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [6:0]        alu_op;
    logic [DATA_W-1:0] alu_x;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] pc_out;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] d_out;

    hack_cpu_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .dmem_re    (dmem_re),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .alu_op     (alu_op),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result),
        .pc_out     (pc_out),
        .a_out      (a_out),
        .d_out      (d_out)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned viol   = 0;

    logic [15:0] mem [32768];
    logic [14:0] m_pc;
    logic [15:0] m_a;
    logic [15:0] m_d;

    logic [5:0] comp_tab [18] = '{COMP_ZERO, COMP_ONE, COMP_NEG1, COMP_X, COMP_Y,
        COMP_NOT_X, COMP_NOT_Y, COMP_NEG_X, COMP_NEG_Y, COMP_X_INC, COMP_Y_INC,
        COMP_X_DEC, COMP_Y_DEC, COMP_X_ADD, COMP_X_SUB, COMP_Y_SUB, COMP_X_AND,
        COMP_X_OR};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [5:0] c, input logic [15:0] x,
                                            input logic [15:0] y);
        case (c)
            COMP_ZERO:  return 16'd0;
            COMP_ONE:   return 16'd1;
            COMP_NEG1:  return 16'hFFFF;
            COMP_X:     return x;
            COMP_Y:     return y;
            COMP_NOT_X: return ~x;
            COMP_NOT_Y: return ~y;
            COMP_NEG_X: return 16'd0 - x;
            COMP_NEG_Y: return 16'd0 - y;
            COMP_X_INC: return x + 16'd1;
            COMP_Y_INC: return y + 16'd1;
            COMP_X_DEC: return x - 16'd1;
            COMP_Y_DEC: return y - 16'd1;
            COMP_X_ADD: return x + y;
            COMP_X_SUB: return x - y;
            COMP_Y_SUB: return y - x;
            COMP_X_AND: return x & y;
            COMP_X_OR:  return x | y;
            default:    return 16'd0;
        endcase
    endfunction

    // Registered ALU emulation: result appears the cycle after the opcode.
    always_ff @(posedge clk) alu_result <= alu_ref(alu_op[5:0], alu_x, alu_y);

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones({imem_req, dmem_re, dmem_we}) > 1) viol++;
            if ((imem_req || dmem_re || dmem_we) && alu_op != 7'd0) viol++;
            if (imem_addr != pc_out) viol++;
        end
    end

    task automatic model_reset();
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
    endtask

    task automatic wait_fetch(output bit ok);
        int unsigned n = 0;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fetch_wait", 32'(imem_req), 1);
        ok = imem_req;
    endtask

    task automatic run_instr(input logic [15:0] instr, input int unsigned fd,
                             input int unsigned dd);
        logic [15:0] y, r, old_a, old_d;
        logic        take, is_c, rd, wr;
        int unsigned lat, exp_lat, rcyc, wcyc, exec_idx;
        bit          ok;
        wait_fetch(ok);
        if (!ok) return;
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        repeat (fd) @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = instr;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'($urandom);

        old_a = m_a;
        old_d = m_d;
        is_c  = instr[15];
        rd    = is_c & instr[12];
        wr    = is_c & instr[3];
        y     = instr[12] ? mem[old_a[14:0]] : old_a;
        r     = alu_ref(instr[11:6], old_d, y);
        if (!is_c) begin
            m_a     = {1'b0, instr[14:0]};
            m_pc    = m_pc + 15'd1;
            exp_lat = 2;
        end else begin
            take = (instr[2] && $signed(r) < 0) || (instr[1] && r == 16'd0)
                || (instr[0] && $signed(r) > 0);
            m_pc = take ? old_a[14:0] : m_pc + 15'd1;
            if (instr[5]) m_a = r;
            if (instr[4]) m_d = r;
            exp_lat = 4 + (rd ? dd + 1 : 0) + (wr ? dd + 1 : 0);
        end
        exec_idx = rd ? 3 + dd : 2;

        lat  = 1;
        rcyc = 0;
        wcyc = 0;
        while (!imem_req && lat < 100) begin
            dmem_ack   = 1'b0;
            dmem_rdata = 16'($urandom);
            if (is_c && lat == exec_idx) begin
                check("alu_op", 32'(alu_op), 32'({1'b0, instr[11:6]}));
                check("alu_x", 32'(alu_x), 32'(old_d));
                check("alu_y", 32'(alu_y), 32'(y));
            end
            if (dmem_re) begin
                if (rcyc == 0) check("rd_addr", 32'(dmem_addr), 32'(old_a[14:0]));
                if (rcyc == dd) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = mem[dmem_addr];
                end
                rcyc++;
            end
            if (dmem_we) begin
                check("wr_addr", 32'(dmem_addr), 32'(old_a[14:0]));
                check("wr_data", 32'(dmem_wdata), 32'(r));
                if (wcyc == dd) begin
                    dmem_ack = 1'b1;
                    mem[dmem_addr] = dmem_wdata;
                end
                wcyc++;
            end
            @(negedge clk);
            lat++;
        end
        dmem_ack = 1'b0;
        check("rd_cycles", rcyc, rd ? dd + 1 : 0);
        check("wr_cycles", wcyc, wr ? dd + 1 : 0);
        check("latency", lat, exp_lat);
        check("pc", 32'(pc_out), 32'(m_pc));
        check("a", 32'(a_out), 32'(m_a));
        check("d", 32'(d_out), 32'(m_d));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_imem_req"}, 32'(imem_req), 0);
        check({tag, "_dmem_re"}, 32'(dmem_re), 0);
        check({tag, "_dmem_we"}, 32'(dmem_we), 0);
        check({tag, "_pc"}, 32'(pc_out), 0);
        check({tag, "_a"}, 32'(a_out), 0);
        check({tag, "_d"}, 32'(d_out), 0);
        check({tag, "_alu_op"}, 32'(alu_op), 0);
        check({tag, "_wdata"}, 32'(dmem_wdata), 0);
    endtask

    task automatic reset_in_fetch();
        bit ok;
        wait_fetch(ok);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_fetch");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic abort_write(input int unsigned hold);
        bit          ok;
        int unsigned n = 0;
        wait_fetch(ok);
        imem_ack  = 1'b1;
        imem_data = 16'hE7C8;
        @(negedge clk);
        imem_ack = 1'b0;
        while (!dmem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort_we_seen", 32'(dmem_we), 1);
        repeat (hold) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("rst_mwrite");
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] ins;
        logic [5:0]  comp;
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[9] = 16'd1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        run_instr(16'h0005, 0, 0);
        run_instr(16'hEC10, 0, 0);
        run_instr(16'h0007, 0, 0);
        run_instr(16'hE7C8, 1, 3);
        check("mem7", 32'(mem[7]), 6);
        run_instr(16'h0064, 0, 0);
        run_instr(16'hE301, 0, 0);
        run_instr(16'hEA90, 0, 0);
        run_instr(16'h0064, 0, 0);
        run_instr(16'hE301, 0, 0);
        run_instr(16'h7FFF, 0, 0);
        run_instr(16'hEDD0, 0, 0);
        run_instr(16'h0064, 0, 0);
        run_instr(16'hE301, 2, 0);
        run_instr(16'h0009, 0, 0);
        run_instr(16'hFCA8, 0, 1);
        check("mem9", 32'(mem[9]), 0);

        run_instr(16'h7FFF, 0, 0);
        run_instr(16'hEA87, 0, 0);
        run_instr(16'h0003, 0, 0);
        run_instr(16'h7FFF, 0, 0);
        run_instr(16'hEA87, 0, 0);
        reset_in_fetch();

        run_instr(16'h0004, 0, 0);
        abort_write(2);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                ins = {1'b0, 15'($urandom)};
            end else begin
                comp = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                                   : comp_tab[$urandom_range(0, 17)];
                ins = {3'b111, 1'($urandom), comp, 3'($urandom), 3'($urandom)};
            end
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        check("protocol", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
